// File: rtl/srio_target_manage.sv
`default_nettype none
// ============================================================================
// Module   : srio_target_manage
// Brief    : Inbound SRIO target manager. Queues doorbells in a small FIFO,
//            tracks NWRITE completions, raises a level interrupt to the DSP and
//            exposes status/counters/queue on the asynchronous host bus.
// Revision : 1.0 - initial release
// ============================================================================
module srio_target_manage #(
    parameter int DB_FIFO_DEPTH = 16,
    parameter int DB_CNT_W      = 5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        srio_single_rdn,
    input  logic        srio_single_wrn,
    input  logic        srio_single_csn,
    input  logic [7:0]  srio_single_addr,
    input  logic [31:0] srio_single_dout,
    output logic [31:0] srio_single_din,
    input  logic        tgt_db_valid,
    input  logic [7:0]  tgt_db_src_id,
    input  logic [15:0] tgt_db_info,
    input  logic        tgt_wr_done,
    input  logic [33:0] tgt_wr_addr,
    input  logic [8:0]  tgt_wr_byte_count,
    output logic        db_irq
);

    localparam int PTR_W = (DB_FIFO_DEPTH > 1) ? $clog2(DB_FIFO_DEPTH) : 1;
    localparam logic [DB_CNT_W-1:0] FULL_CNT = DB_CNT_W'(DB_FIFO_DEPTH);

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_DB_DATA = 8'h04;
    localparam logic [7:0] ADDR_IRQ_EN  = 8'h08;
    localparam logic [7:0] ADDR_IRQ_CLR = 8'h0C;
    localparam logic [7:0] ADDR_WR_LO   = 8'h10;
    localparam logic [7:0] ADDR_WR_INFO = 8'h14;
    localparam logic [7:0] ADDR_WR_CNT  = 8'h18;
    localparam logic [7:0] ADDR_DB_CNT  = 8'h1C;

    // Strobe synchronizers; sync_vld marks when the pipeline holds real samples
    logic        csn_s1_q, csn_s1_d, csn_s2_q, csn_s2_d;
    logic        rdn_s1_q, rdn_s1_d, rdn_s2_q, rdn_s2_d;
    logic        wrn_s1_q, wrn_s1_d, wrn_s2_q, wrn_s2_d;
    logic [1:0]  sync_vld_q, sync_vld_d;

    // Host access tracking
    logic        rd_idle_q, rd_idle_d;
    logic        rd_busy_q, rd_busy_d;
    logic        rd_pop_q, rd_pop_d;
    logic        wr_idle_q, wr_idle_d;
    logic        rd_act, wr_act, rd_rise, rd_fall, wr_rise;

    // Doorbell queue
    logic [23:0]         mem_q [DB_FIFO_DEPTH];
    logic [23:0]         mem_d [DB_FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DB_CNT_W-1:0] occ_q, occ_d;
    logic                push, pop, full;

    // Status / configuration / counters
    logic        ovf_q, ovf_d, wrd_q, wrd_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic [33:0] last_addr_q, last_addr_d;
    logic [8:0]  last_cnt_q, last_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d, db_cnt_q, db_cnt_d;
    logic [31:0] din_q, din_d, rd_data, status;
    logic        irq_q, irq_d;
    logic        clr_ovf, clr_wrd;
    logic        unused_dout;

    assign unused_dout = ^srio_single_dout[31:2];

    assign rd_act  = !csn_s2_q && !rdn_s2_q;
    assign wr_act  = !csn_s2_q && !wrn_s2_q;
    // A strobe only counts as a new edge after it has been seen idle with real samples
    assign rd_rise = rd_act && rd_idle_q;
    assign rd_fall = !rd_act && rd_busy_q;
    assign wr_rise = wr_act && wr_idle_q;

    // Synchronizer shift and host access edge bookkeeping
    always_comb begin
        csn_s1_d   = srio_single_csn;
        csn_s2_d   = csn_s1_q;
        rdn_s1_d   = srio_single_rdn;
        rdn_s2_d   = rdn_s1_q;
        wrn_s1_d   = srio_single_wrn;
        wrn_s2_d   = wrn_s1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        rd_idle_d  = sync_vld_q[1] && !rd_act;
        wr_idle_d  = sync_vld_q[1] && !wr_act;
        rd_busy_d  = rd_busy_q ? rd_act : rd_rise;
        rd_pop_d   = rd_pop_q;
        if (rd_rise) begin
            // Decide at latch time whether this access owns the head entry
            rd_pop_d = (srio_single_addr == ADDR_DB_DATA) && (occ_q != '0);
        end else if (rd_fall) begin
            rd_pop_d = 1'b0;
        end
    end

    // Doorbell FIFO: pop is applied before push so a full queue accepts on a pop cycle
    always_comb begin
        full     = (occ_q == FULL_CNT);
        pop      = rd_fall && rd_pop_q && (occ_q != '0);
        push     = tgt_db_valid && (!full || pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = {tgt_db_src_id, tgt_db_info};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + DB_CNT_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - DB_CNT_W'(1);
        end
    end

    // Register writes, sticky bits (set beats clear), counters and interrupt
    always_comb begin
        clr_ovf     = wr_rise && (srio_single_addr == ADDR_IRQ_CLR) && srio_single_dout[0];
        clr_wrd     = wr_rise && (srio_single_addr == ADDR_IRQ_CLR) && srio_single_dout[1];
        ovf_d       = (ovf_q && !clr_ovf) || (tgt_db_valid && !push);
        wrd_d       = (wrd_q && !clr_wrd) || tgt_wr_done;
        irq_en_d    = irq_en_q;
        if (wr_rise && (srio_single_addr == ADDR_IRQ_EN)) begin
            irq_en_d = srio_single_dout[1:0];
        end
        last_addr_d = last_addr_q;
        last_cnt_d  = last_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (tgt_wr_done) begin
            last_addr_d = tgt_wr_addr;
            last_cnt_d  = tgt_wr_byte_count;
            wr_cnt_d    = wr_cnt_q + 32'd1;
        end
        db_cnt_d    = push ? db_cnt_q + 32'd1 : db_cnt_q;
        irq_d       = (irq_en_q[0] && (occ_q != '0)) || (irq_en_q[1] && wrd_q);
    end

    // Read data mux; din is captured only on the read strobe's leading edge
    always_comb begin
        status                 = 32'h7A61_0000;
        status[DB_CNT_W-1:0]   = occ_q;
        status[8]              = ovf_q;
        status[9]              = wrd_q;
        case (srio_single_addr)
            ADDR_STATUS:  rd_data = status;
            ADDR_DB_DATA: rd_data = (occ_q != '0) ? {8'h00, mem_q[rd_ptr_q]} : 32'h0;
            ADDR_IRQ_EN:  rd_data = {30'h0, irq_en_q};
            ADDR_WR_LO:   rd_data = last_addr_q[31:0];
            ADDR_WR_INFO: rd_data = {21'h0, last_cnt_q, last_addr_q[33:32]};
            ADDR_WR_CNT:  rd_data = wr_cnt_q;
            ADDR_DB_CNT:  rd_data = db_cnt_q;
            default:      rd_data = 32'h0;
        endcase
        din_d = rd_rise ? rd_data : din_q;
    end

    // Queue storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    // State registers with synchronous reset; synchronizers idle high
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            csn_s1_q    <= 1'b1;
            csn_s2_q    <= 1'b1;
            rdn_s1_q    <= 1'b1;
            rdn_s2_q    <= 1'b1;
            wrn_s1_q    <= 1'b1;
            wrn_s2_q    <= 1'b1;
            sync_vld_q  <= 2'b00;
            rd_idle_q   <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_pop_q    <= 1'b0;
            wr_idle_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            ovf_q       <= 1'b0;
            wrd_q       <= 1'b0;
            irq_en_q    <= 2'b00;
            last_addr_q <= '0;
            last_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            db_cnt_q    <= '0;
            din_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            csn_s1_q    <= csn_s1_d;
            csn_s2_q    <= csn_s2_d;
            rdn_s1_q    <= rdn_s1_d;
            rdn_s2_q    <= rdn_s2_d;
            wrn_s1_q    <= wrn_s1_d;
            wrn_s2_q    <= wrn_s2_d;
            sync_vld_q  <= sync_vld_d;
            rd_idle_q   <= rd_idle_d;
            rd_busy_q   <= rd_busy_d;
            rd_pop_q    <= rd_pop_d;
            wr_idle_q   <= wr_idle_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            ovf_q       <= ovf_d;
            wrd_q       <= wrd_d;
            irq_en_q    <= irq_en_d;
            last_addr_q <= last_addr_d;
            last_cnt_q  <= last_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            db_cnt_q    <= db_cnt_d;
            din_q       <= din_d;
            irq_q       <= irq_d;
        end
    end

    assign srio_single_din = din_q;
    assign db_irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_srio_target_manage.sv
`default_nettype none
// ============================================================================
// Module   : tb_srio_target_manage
// Brief    : Self-checking bench for srio_target_manage with a queue-based
//            reference model of the register map and doorbell FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srio_target_manage;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdn = 1'b1, wrn = 1'b1, csn = 1'b1;
    logic [7:0]  addr = '0;
    logic [31:0] dout = '0;
    logic [31:0] din;
    logic        db_valid = 1'b0;
    logic [7:0]  db_src = '0;
    logic [15:0] db_info = '0;
    logic        wr_done = 1'b0;
    logic [33:0] wr_addr = '0;
    logic [8:0]  wr_bc = '0;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [23:0] mq[$];
    bit          m_ovf, m_wrd;
    logic [1:0]  m_en;
    logic [33:0] m_last_addr;
    logic [8:0]  m_last_cnt;
    logic [31:0] m_wr_cnt, m_db_cnt;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    srio_target_manage #(.DB_FIFO_DEPTH(DEPTH), .DB_CNT_W(5)) dut (
        .sys_clk           (clk),
        .sys_rst           (rst),
        .srio_single_rdn   (rdn),
        .srio_single_wrn   (wrn),
        .srio_single_csn   (csn),
        .srio_single_addr  (addr),
        .srio_single_dout  (dout),
        .srio_single_din   (din),
        .tgt_db_valid      (db_valid),
        .tgt_db_src_id     (db_src),
        .tgt_db_info       (db_info),
        .tgt_wr_done       (wr_done),
        .tgt_wr_addr       (wr_addr),
        .tgt_wr_byte_count (wr_bc),
        .db_irq            (irq)
    );

    function automatic void model_reset();
        mq.delete();
        m_ovf = 0; m_wrd = 0; m_en = 2'b00;
        m_last_addr = '0; m_last_cnt = '0;
        m_wr_cnt = 0; m_db_cnt = 0; last_rd = 0;
    endfunction

    function automatic void model_push(input logic [7:0] s, input logic [15:0] i);
        if (mq.size() < DEPTH) begin
            mq.push_back({s, i});
            m_db_cnt = m_db_cnt + 1;
        end else begin
            m_ovf = 1;
        end
    endfunction

    function automatic logic [31:0] model_peek(input logic [7:0] a);
        case (a)
            8'h00: return 32'h7A61_0000 + 32'(mq.size()) + (m_ovf ? 32'h100 : 32'h0)
                          + (m_wrd ? 32'h200 : 32'h0);
            8'h04: return (mq.size() != 0) ? {8'h00, mq[0]} : 32'h0;
            8'h08: return {30'h0, m_en};
            8'h10: return m_last_addr[31:0];
            8'h14: return {21'h0, m_last_cnt, m_last_addr[33:32]};
            8'h18: return m_wr_cnt;
            8'h1C: return m_db_cnt;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_irq();
        return (m_en[0] && mq.size() != 0) || (m_en[1] && m_wrd);
    endfunction

    // All tasks start and end 1 time unit after a rising clock edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic db_pulse(input logic [7:0] s, input logic [15:0] i);
        db_valid = 1'b1; db_src = s; db_info = i;
        tick(1);
        db_valid = 1'b0;
        model_push(s, i);
    endtask

    task automatic wrdone_pulse(input logic [33:0] a, input logic [8:0] c);
        wr_done = 1'b1; wr_addr = a; wr_bc = c;
        tick(1);
        wr_done = 1'b0;
        m_wrd = 1; m_last_addr = a; m_last_cnt = c; m_wr_cnt = m_wr_cnt + 1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [31:0] d);
        addr = a; dout = d; csn = 1'b0; wrn = 1'b0;
        tick(6);
        csn = 1'b1; wrn = 1'b1;
        tick(6);
        if (a == 8'h08) m_en = d[1:0];
        if (a == 8'h0C) begin
            if (d[0]) m_ovf = 0;
            if (d[1]) m_wrd = 0;
        end
    endtask

    task automatic check_read(input string name, input logic [7:0] a);
        logic [31:0] exp, v;
        exp = model_peek(a);
        addr = a; csn = 1'b0; rdn = 1'b0;
        tick(6);
        v = din;
        csn = 1'b1; rdn = 1'b1;
        tick(6);
        if (a == 8'h04 && mq.size() != 0) void'(mq.pop_front());
        last_rd = exp;
        checks++;
        if (v !== exp) begin
            failures++;
            $display("FAIL %s addr=%02h got=%08h expected=%08h", name, a, v, exp);
        end
    endtask

    task automatic check_irq(input string name);
        tick(2);
        checks++;
        if (irq !== model_irq()) begin
            failures++;
            $display("FAIL %s db_irq got=%b expected=%b", name, irq, model_irq());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        model_reset();
        tick(4);
        checks++;
        if (din !== 32'h0) begin
            failures++;
            $display("FAIL reset_din got=%08h expected=%08h", din, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b expected=0", irq);
        end
        check_read("reset_status", 8'h00);
        check_read("reset_irq_en", 8'h08);
    endtask

    task automatic test_single_doorbell();
        host_write(8'h08, 32'h1);
        db_pulse(8'h12, 16'hBEEF);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL db_irq_early got=%b expected=0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL db_irq_rise got=%b expected=1", irq);
        end
        check_read("single_db_data", 8'h04);
        check_read("single_status", 8'h00);
        check_irq("single_irq_fall");
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) db_pulse(8'hA0, 16'(i));
        check_read("ovf_status", 8'h00);
        check_read("ovf_db_cnt", 8'h1C);
        for (int i = 0; i < DEPTH; i++) check_read($sformatf("ovf_pop%0d", i), 8'h04);
        check_read("ovf_empty_read", 8'h04);
        host_write(8'h0C, 32'h1);
        check_read("ovf_cleared", 8'h00);
    endtask

    task automatic test_full_coincide();
        logic [31:0] exp, v;
        for (int i = 0; i < DEPTH; i++) db_pulse(8'h5C, 16'h100 + 16'(i));
        exp = model_peek(8'h04);
        addr = 8'h04; csn = 1'b0; rdn = 1'b0;
        tick(6);
        v = din;
        csn = 1'b1; rdn = 1'b1;
        tick(2);
        // Doorbell lands on the same edge that retires the pop
        db_valid = 1'b1; db_src = 8'h77; db_info = 16'hC0DE;
        tick(1);
        db_valid = 1'b0;
        void'(mq.pop_front());
        model_push(8'h77, 16'hC0DE);
        tick(6);
        checks++;
        if (v !== exp) begin
            failures++;
            $display("FAIL coincide_head got=%08h expected=%08h", v, exp);
        end
        check_read("coincide_status", 8'h00);
        for (int i = 0; i < DEPTH; i++) check_read($sformatf("coincide_drain%0d", i), 8'h04);
    endtask

    task automatic test_wr_done();
        wrdone_pulse(34'h3_0000_1000, 9'd256);
        check_read("wr_lo", 8'h10);
        check_read("wr_info", 8'h14);
        check_read("wr_cnt", 8'h18);
        host_write(8'h08, 32'h2);
        check_irq("wr_irq_set");
        host_write(8'h0C, 32'h2);
        check_irq("wr_irq_clr");
        // Clear write committing on the same edge as a new completion
        addr = 8'h0C; dout = 32'h2; csn = 1'b0; wrn = 1'b0;
        tick(2);
        wr_done = 1'b1; wr_addr = 34'h1_2345_6789; wr_bc = 9'd17;
        tick(1);
        wr_done = 1'b0;
        tick(3);
        csn = 1'b1; wrn = 1'b1;
        tick(6);
        m_wrd = 1; m_last_addr = 34'h1_2345_6789; m_last_cnt = 9'd17;
        m_wr_cnt = m_wr_cnt + 1;
        check_read("wr_set_wins", 8'h00);
        check_irq("wr_set_wins_irq");
        check_read("wr_info2", 8'h14);
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] ra [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20};
        logic [7:0] wa [4] = '{8'h08, 8'h0C, 8'h18, 8'h00};
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int n = $urandom_range(1, 5);
                    for (int k = 0; k < n; k++)
                        db_pulse(8'($urandom), 16'($urandom));
                end
                1: wrdone_pulse({2'($urandom), 32'($urandom)}, 9'($urandom));
                2: check_read($sformatf("rnd_read%0d", it), ra[$urandom_range(0, 8)]);
                default: begin
                    host_write(wa[$urandom_range(0, 3)], $urandom);
                    checks++;
                    if (din !== last_rd) begin
                        failures++;
                        $display("FAIL rnd_din_hold%0d got=%08h expected=%08h", it, din, last_rd);
                    end
                end
            endcase
            check_irq($sformatf("rnd_irq%0d", it));
        end
        check_read("rnd_status_end", 8'h00);
        check_read("rnd_db_cnt_end", 8'h1C);
    endtask

    task automatic test_reset_mid_read();
        db_pulse(8'h01, 16'h1111);
        db_pulse(8'h02, 16'h2222);
        addr = 8'h04; csn = 1'b0; rdn = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(6);
        checks++;
        if (din !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_din got=%08h expected=%08h", din, 32'h0);
        end
        db_pulse(8'h33, 16'h3333);
        tick(4);
        csn = 1'b1; rdn = 1'b1;
        tick(8);
        check_read("rst_mid_status", 8'h00);
        check_read("rst_mid_data", 8'h04);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_doorbell();
        test_overflow();
        test_full_coincide();
        test_wr_done();
        test_back_to_back_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/srio_target_manage.md
# srio_target_manage

Inbound-side companion to the SRIO initiator manager. It receives doorbells and NWRITE-completion notices from the SRIO target port and queues doorbells in a small FIFO. It raises an interrupt to the DSP and exposes status, counters and the doorbell queue through the same asynchronous single-word host bus (rdn/wrn/csn/addr/dout/din) used for initiator configuration. It sits between the SRIO core's target interface and the DSP EMIF-style register bus.

## Interface

Parameters:
- DB_FIFO_DEPTH, 16: doorbell queue depth. Must be a power of 2, 2..64.
- DB_CNT_W, 5: occupancy width, log2(DB_FIFO_DEPTH)+1.

Ports:
- sys_clk  in  1  system clock. This is the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- srio_single_rdn  in  1  host read strobe, active low, asynchronous to sys_clk.
- srio_single_wrn  in  1  host write strobe, active low, asynchronous to sys_clk.
- srio_single_csn  in  1  host chip select, active low, asynchronous to sys_clk.
- srio_single_addr  in  8  host register address.
- srio_single_dout  in  32  host write data.
- srio_single_din  out  32  host read data, registered.
- tgt_db_valid  in  1  one-cycle pulse: an inbound doorbell has arrived.
- tgt_db_src_id  in  8  source ID of the doorbell.
- tgt_db_info  in  16  doorbell info field.
- tgt_wr_done  in  1  one-cycle pulse: an inbound NWRITE has completed.
- tgt_wr_addr  in  34  destination address of the completed write.
- tgt_wr_byte_count  in  9  byte count of the completed write.
- db_irq  out  1  level interrupt to the DSP, registered.

## Operation

Host bus:
- The csn, rdn and wrn signals each pass through a 2-FF synchronizer.
- rd_act = !csn_s & !rdn_s.
- wr_act = !csn_s & !wrn_s.
- A write commits on the rising edge of wr_act (the cycle it first goes true). addr and dout are sampled directly in that cycle. The host keeps them stable for the full strobe.
- A read latches srio_single_din on the rising edge of rd_act.
- A read of DB_DATA pops the queue on the falling edge of rd_act (the end of the access), so din stays stable while the strobe is low.
- srio_single_din holds its value between reads.
- Undefined addresses read 0. Writes to read-only or undefined addresses are ignored.

Register map:
- 0x00 STATUS (RO):
  - [DB_CNT_W-1:0] queue occupancy.
  - [8] overflow sticky.
  - [9] wr_done sticky.
  - [31:16] 0x7A61.
- 0x04 DB_DATA (RO, read pops the queue): {8'h00, src_id, info}. When the queue is empty, a read returns 0 and does not pop.
- 0x08 IRQ_EN (RW):
  - bit0: doorbell interrupt enable.
  - bit1: write-done interrupt enable.
  - bits [31:2] read 0.
- 0x0C IRQ_CLR (WO), write-1-to-clear:
  - bit0 clears overflow.
  - bit1 clears wr_done.
- 0x10 LAST_WR_ADDR_LO (RO): tgt_wr_addr[31:0] of the most recent tgt_wr_done.
- 0x14 LAST_WR_INFO (RO): {21'h0, byte_count[8:0], addr[33:32]}.
- 0x18 WR_CNT (RO): 32-bit count of tgt_wr_done pulses. Wraps 0xFFFFFFFF→0.
- 0x1C DB_CNT (RO): 32-bit count of accepted (not dropped) doorbells. Wraps.

Doorbell FIFO:
- Register-based circular buffer with separate read and write pointers, plus an occupancy counter.
- tgt_db_valid with the queue not full: push {src_id, info}, and DB_CNT increments.
- tgt_db_valid with the queue full: drop the doorbell and set the overflow sticky. DB_CNT does not change.
- Push and pop in the same cycle, queue full: the pop happens first, the push is accepted, occupancy is unchanged, and no overflow is flagged.
- Push and pop in the same cycle, queue empty: the pop is ignored and the push is accepted (occupancy becomes 1).
- Pointers wrap modulo DB_FIFO_DEPTH.

Sticky bits:
- wr_done sets on tgt_wr_done.
- If a set and a clear land in the same cycle, set wins.
- Same rule applies to overflow.

Interrupt:
- db_irq <= (IRQ_EN[0] & occupancy != 0) | (IRQ_EN[1] & wr_done_sticky).

Reset:
- Pointers, occupancy, stickies, IRQ_EN, counters, LAST_WR registers, srio_single_din and db_irq all go to 0.
- Synchronizer flops reset to 1 (idle).
- Reset asserted mid-transaction: any access in progress is abandoned with no pop and no write.
- After reset, a strobe that is already low is not treated as a new edge until it has returned high.

## Timing

- A strobe low sampled at cycle N is seen in synchronized form at N+2. The edge is acted on at N+2, and registers or din update at N+3.
- Host requirements: strobes low for at least 4 cycles and high for at least 4 cycles; addr and dout stable from strobe fall to strobe rise.
- Doorbell path: tgt_db_valid at cycle N gives occupancy and STATUS updated at N+1, and db_irq high at N+2 (if enabled).
- Pop: rd_act falling at cycle M gives occupancy decremented at M+1, and db_irq reflecting it at M+2.
- Back-to-back tgt_db_valid pulses on consecutive cycles are all accepted while space remains.

## Test plan

- Reset, then read STATUS → 0x7A610000; read IRQ_EN → 0; db_irq = 0.
- Write IRQ_EN = 1; push doorbell src 0x12, info 0xBEEF → db_irq rises 2 cycles later. Read DB_DATA → 0x0012BEEF; occupancy returns to 0 and db_irq falls.
- Push 17 doorbells (info 0..16) with depth 16 → STATUS = 0x7A610110 (occupancy 16, overflow set), DB_CNT = 16. The 16 pops return info 0..15 in order. A 17th read returns 0. IRQ_CLR = 1 clears overflow.
- Queue full, and tgt_db_valid coincides with the DB_DATA pop cycle → occupancy stays 16, no overflow.
- tgt_wr_done with addr 0x3_0000_1000, count 256 → LAST_WR_ADDR_LO = 0x00001000, LAST_WR_INFO = 0x403, WR_CNT = 1. IRQ_EN = 2 raises db_irq. IRQ_CLR = 2 clears it. A clear and a new tgt_wr_done in the same cycle leaves the sticky set.
- Assert sys_rst while a DB_DATA read strobe is low with the queue non-empty → after reset, occupancy = 0, din = 0, and no pop is attributed when the strobe releases.
